// File: rtl/layer_loader.sv
// Streams per-node parameter words from a synchronous ROM onto the shared
// layer bus, one word per cycle, with a one-hot shift enable per node.
module layer_loader #(
    parameter int n  = 16,
    parameter int sx = 2,
    parameter int sl = 3,
    parameter int AW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [AW-1:0]   base,
    output logic            mem_en,
    output logic [AW-1:0]   mem_addr,
    input  logic [n-1:0]    mem_data,
    output logic [sl-1:0]   we,
    inout  wire  [2*n-1:0]  bus,
    output logic            busy,
    output logic            done
);

    localparam int NW = (sl > 1) ? $clog2(sl) : 1;
    localparam int WW = (sx > 0) ? $clog2(sx + 1) : 1;
    localparam logic [AW-1:0] SPAN = AW'(sl * (sx + 1) - 1);
    localparam logic [sl-1:0] TOP = sl'(1) << (sl - 1);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        FLUSH
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] last_q, last_d;
    logic          mem_en_q, mem_en_d;
    logic          vld_q, vld_d;
    logic [NW-1:0] node_q, node_d;
    logic [WW-1:0] word_q, word_d;
    logic          done_q, done_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            last_q   <= '0;
            mem_en_q <= 1'b0;
            vld_q    <= 1'b0;
            node_q   <= '0;
            word_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            last_q   <= last_d;
            mem_en_q <= mem_en_d;
            vld_q    <= vld_d;
            node_q   <= node_d;
            word_q   <= word_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        last_d   = last_q;
        mem_en_d = mem_en_q;
        node_d   = node_q;
        word_d   = word_q;
        done_d   = 1'b0;
        // ROM data lands one cycle after each issued read
        vld_d    = mem_en_q;

        if (vld_q) begin
            if (word_q == WW'(sx)) begin
                word_d = '0;
                node_d = node_q + 1'b1;
            end else begin
                word_d = word_q + 1'b1;
            end
        end

        unique case (state_q)
            IDLE: begin
                // the done cycle still counts as part of the load
                if (start && !done_q) begin
                    state_d  = STREAM;
                    addr_d   = base;
                    last_d   = base + SPAN;
                    mem_en_d = 1'b1;
                    node_d   = '0;
                    word_d   = '0;
                end
            end
            STREAM: begin
                if (addr_q == last_q) begin
                    state_d  = FLUSH;
                    mem_en_d = 1'b0;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            FLUSH: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign we       = vld_q ? (TOP >> node_q) : '0;
    assign bus      = vld_q ? {{n{mem_data[n-1]}}, mem_data} : 'z;
    assign mem_en   = mem_en_q;
    assign mem_addr = addr_q;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;

endmodule

// File: tb/tb_layer_loader.sv
// Directed bench for layer_loader: a 3x(2+1) instance and a 1x(0+1)
// instance sharing one behavioural synchronous ROM.
module tb_layer_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start0 = 1'b0;
    logic        start1 = 1'b0;
    logic [7:0]  base0 = '0;
    logic [7:0]  base1 = '0;
    logic        mem_en0, mem_en1;
    logic [7:0]  addr0, addr1;
    logic [15:0] data0 = '0;
    logic [15:0] data1 = '0;
    logic [2:0]  we0;
    logic [0:0]  we1;
    wire  [31:0] bus0, bus1;
    logic        busy0, busy1, done0, done1;

    logic [15:0] rom [256];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en0) data0 <= rom[addr0];
        if (mem_en1) data1 <= rom[addr1];
    end

    layer_loader #(.n(16), .sx(2), .sl(3), .AW(8)) u_dut (
        .clk(clk), .rst(rst), .start(start0), .base(base0),
        .mem_en(mem_en0), .mem_addr(addr0), .mem_data(data0),
        .we(we0), .bus(bus0), .busy(busy0), .done(done0)
    );

    layer_loader #(.n(16), .sx(0), .sl(1), .AW(8)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .base(base1),
        .mem_en(mem_en1), .mem_addr(addr1), .mem_data(data1),
        .we(we1), .bus(bus1), .busy(busy1), .done(done1)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sext(input int a);
        logic [15:0] w;
        w = rom[a];
        return {{16{w[15]}}, w};
    endfunction

    function automatic logic released(input logic [31:0] v);
        return (v === 32'hzzzz_zzzz) || (v === 32'h0);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Full load on the 3-node instance; optional extra start mid-load
    // and in the done cycle, both of which must be ignored.
    task automatic load0(input logic [7:0] b, input bit mid,
                         input bit at_done);
        assert (int'(b) + 9 <= 256);
        start0 = 1'b1;
        base0  = b;
        tick;
        start0 = 1'b0;
        chk("busy_t1", 32'(busy0), 32'd1);
        chk("mem_en_t1", 32'(mem_en0), 32'd1);
        chk("addr_t1", 32'(addr0), 32'(b));
        chk("we_t1", 32'(we0), 32'd0);
        for (int k = 0; k < 9; k++) begin
            tick;
            start0 = (mid && k == 3);
            chk("we", 32'(we0), 32'(3'b100 >> (k / 3)));
            chk("bus", bus0, sext(int'(b) + k));
            chk("busy", 32'(busy0), 32'd1);
            chk("done_early", 32'(done0), 32'd0);
            if (k < 8) begin
                chk("mem_en", 32'(mem_en0), 32'd1);
                chk("addr", 32'(addr0), 32'(int'(b) + k + 1));
            end else begin
                chk("mem_en_flush", 32'(mem_en0), 32'd0);
            end
        end
        start0 = 1'b0;
        tick;
        chk("done", 32'(done0), 32'd1);
        chk("busy_done", 32'(busy0), 32'd0);
        chk("we_done", 32'(we0), 32'd0);
        chk("bus_z_done", 32'(released(bus0)), 32'd1);
        start0 = at_done;
        tick;
        start0 = 1'b0;
        chk("done_pulse", 32'(done0), 32'd0);
        chk("busy_after", 32'(busy0), 32'd0);
        chk("mem_en_after", 32'(mem_en0), 32'd0);
    endtask

    initial begin
        for (int a = 0; a < 256; a++) rom[a] = 16'(a + 1);
        rst = 1'b0;
        tick;
        tick;
        chk("rst_mem_en", 32'(mem_en0), 32'd0);
        chk("rst_addr", 32'(addr0), 32'd0);
        chk("rst_we", 32'(we0), 32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_done", 32'(done0), 32'd0);
        chk("rst_bus_z", 32'(released(bus0)), 32'd1);
        rst = 1'b1;
        tick;

        load0(8'd0, 1'b0, 1'b0);
        load0(8'd9, 1'b0, 1'b0);
        load0(8'd0, 1'b1, 1'b1);

        rom[4] = 16'hFFFD;
        start0 = 1'b1;
        base0  = 8'd4;
        tick;
        start0 = 1'b0;
        tick;
        chk("neg_we", 32'(we0), 32'b100);
        chk("neg_bus", bus0, 32'hFFFF_FFFD);
        repeat (10) tick;
        rom[4] = 16'd5;

        start0 = 1'b1;
        base0  = 8'd0;
        tick;
        start0 = 1'b0;
        repeat (5) tick;
        rst = 1'b0;
        #1;
        chk("abort_we", 32'(we0), 32'd0);
        chk("abort_bus_z", 32'(released(bus0)), 32'd1);
        chk("abort_busy", 32'(busy0), 32'd0);
        chk("abort_mem_en", 32'(mem_en0), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick;
        load0(8'd0, 1'b0, 1'b0);

        start1 = 1'b1;
        base1  = 8'd7;
        tick;
        start1 = 1'b0;
        chk("s1_addr", 32'(addr1), 32'd7);
        chk("s1_mem_en", 32'(mem_en1), 32'd1);
        chk("s1_we_t1", 32'(we1), 32'd0);
        tick;
        chk("s1_we", 32'(we1), 32'd1);
        chk("s1_bus", bus1, 32'd8);
        chk("s1_busy", 32'(busy1), 32'd1);
        tick;
        chk("s1_done", 32'(done1), 32'd1);
        chk("s1_we_off", 32'(we1), 32'd0);
        chk("s1_busy_off", 32'(busy1), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
